perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 13 +
 rtl/perf_counter_ch.sv | 36 +++
 rtl/perf_counter_bank.sv | 94 +++++++++
 tb/tb_perf_counter_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_CH = 4;

endpackage

// File: rtl/perf_counter_ch.sv
// One wrapping event counter with a sticky overflow flag set on the all-ones -> 0 edge.
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;

  // NOTE: reset is sampled on the clock edge only (synchronous), so it sits inside the
  // clocked branch rather than in the sensitivity list; state updates use <= so every
  // register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_inc) begin
      r_count <= r_count + ONE;
      if (&r_count) r_ovf <= 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters under an IDLE/RUN/HALT control FSM.
// Optional feature: define PERF_SNAPSHOT_EN to add a snap input and a readout snapshot.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = DEFAULT_NUM_CH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
`ifdef PERF_SNAPSHOT_EN
  input  logic                      snap,
`endif
  input  logic [NUM_CH-1:0]         evt,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      running,
  output logic [NUM_CH-1:0]         ovf
);

  state_e r_state;
  state_e w_state_nxt;

  logic              w_run;
  logic [NUM_CH-1:0] w_inc;
  logic [WIDTH-1:0]  w_cnt [NUM_CH];
  logic [WIDTH-1:0]  w_src [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    running     = (r_state == RUN);
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (!stop && start && (r_state != RUN)) begin
      w_state_nxt = RUN;
    end else if (stop && (r_state == RUN)) begin
      w_state_nxt = HALT;
    end
  end

  // Increments follow the registered state, so the edge entering RUN counts nothing
  // and the edge leaving RUN still counts.
  assign w_run = (r_state == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_inc[i] = w_run & (evt[i] | (i == 0));

    perf_counter_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_inc[i]),
      .i_clr   (clear),
      .o_count (w_cnt[i]),
      .o_ovf   (ovf[i])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic [WIDTH-1:0] r_snap [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= w_cnt[i];
    end
  end

  assign w_src = r_snap;
`else
  assign w_src = w_cnt;
`endif

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(rd_sel) == i) rd_data = w_src[i];
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench: a 32-bit/4-channel bank for control behaviour and a
// 4-bit/5-channel bank for wrap, overflow and out-of-range readout.
module tb_perf_counter_bank;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NW = 4;
  localparam int NN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, stop, clear;
  logic [N-1:0]  evt;
  logic [1:0]    rd_sel;
  logic [W-1:0]  rd_data;
  logic          running;
  logic [N-1:0]  ovf;

  logic          n_start, n_stop, n_clear;
  logic [NN-1:0] n_evt;
  logic [2:0]    n_sel;
  logic [NW-1:0] n_data;
  logic          n_running;
  logic [NN-1:0] n_ovf;

`ifdef PERF_SNAPSHOT_EN
  logic snap, n_snap;
`endif

  int checks   = 0;
  int failures = 0;

  perf_counter_bank #(.WIDTH(W), .NUM_CH(N)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
`ifdef PERF_SNAPSHOT_EN
    .snap    (snap),
`endif
    .evt     (evt),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .running (running),
    .ovf     (ovf)
  );

  perf_counter_bank #(.WIDTH(NW), .NUM_CH(NN)) u_narrow (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (n_start),
    .stop    (n_stop),
    .clear   (n_clear),
`ifdef PERF_SNAPSHOT_EN
    .snap    (n_snap),
`endif
    .evt     (n_evt),
    .rd_sel  (n_sel),
    .rd_data (n_data),
    .running (n_running),
    .ovf     (n_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Live counter reads; with the snapshot build rd_data shows the snapshot instead.
  task automatic check_ch(input string tag, input int ch, input logic [63:0] exp);
`ifndef PERF_SNAPSHOT_EN
    rd_sel = 2'(ch);
    #1;
    check(tag, 64'(rd_data), exp);
`endif
  endtask

  task automatic check_nch(input string tag, input int ch, input logic [63:0] exp);
`ifndef PERF_SNAPSHOT_EN
    n_sel = 3'(ch);
    #1;
    check(tag, 64'(n_data), exp);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; evt = '0; rd_sel = '0;
    n_start = 1'b0; n_stop = 1'b0; n_clear = 1'b0; n_evt = '0; n_sel = '0;
`ifdef PERF_SNAPSHOT_EN
    snap = 1'b0; n_snap = 1'b0;
`endif
    tick(2);

    check("reset_running", 64'(running), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < N; i++) check_ch("reset_cnt", i, 64'd0);

    // First edge out of reset is a normal cycle; entering RUN counts nothing.
    rst_n = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("lat_running", 64'(running), 64'd1);
    check_ch("lat_ch0_T", 0, 64'd0);
    tick(1);
    check_ch("lat_ch0_T1", 0, 64'd1);
    tick(4);
    check_ch("lat_ch0_T5", 0, 64'd5);
    check_ch("lat_ch1_noevt", 1, 64'd0);

    // Reset mid-RUN overrides start and events.
    tick(5);
    check_ch("pre_rst_ch0", 0, 64'd10);
    rst_n = 1'b0; start = 1'b1; evt = '1;
    tick(1);
    check("rst_running", 64'(running), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < N; i++) check_ch("rst_cnt", i, 64'd0);
    rst_n = 1'b1; evt = '0;
    tick(1);
    start = 1'b0;
    check("post_rst_start", 64'(running), 64'd1);
    check_ch("post_rst_ch0", 0, 64'd0);

    // Event gating: ch2 sees 3 of 7 cycles, ch3 all 7, evt[0] ignored; stop on 7th.
    begin
      logic [6:0] pat;
      pat = 7'b0100101;
      for (int i = 0; i < 7; i++) begin
        evt  = {1'b1, pat[i], 1'b0, 1'b1};
        stop = (i == 6);
        tick(1);
      end
    end
    stop = 1'b0;
    check("gate_halted", 64'(running), 64'd0);
    check_ch("gate_ch0", 0, 64'd7);
    check_ch("gate_ch1", 1, 64'd0);
    check_ch("gate_ch2", 2, 64'd3);
    check_ch("gate_ch3", 3, 64'd7);
    evt = '1;
    tick(20);
    check("halt_running", 64'(running), 64'd0);
    check_ch("halt_ch0", 0, 64'd7);
    check_ch("halt_ch2", 2, 64'd3);
    check_ch("halt_ch3", 3, 64'd7);
    evt = '0; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("resume_running", 64'(running), 64'd1);
    check_ch("resume_ch0_T", 0, 64'd7);
    tick(1);
    check_ch("resume_ch0_T1", 0, 64'd8);

    // start and stop together in RUN go to HALT, still counting that edge.
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("both_halt", 64'(running), 64'd0);
    check_ch("both_ch0", 0, 64'd9);

    // clear beats everything in the same cycle.
    start = 1'b1;
    tick(1);
    clear = 1'b1; stop = 1'b1; start = 1'b1; evt = '1;
    tick(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0; evt = '0;
    check("clr_running", 64'(running), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < N; i++) check_ch("clr_cnt", i, 64'd0);
    tick(2);
    check_ch("clr_idle_ch0", 0, 64'd0);

    // Narrow bank: wrap of a 4-bit counter and sticky overflow.
    n_evt = 5'b00010; n_start = 1'b1;
    tick(1);
    n_start = 1'b0;
    check("n_running", 64'(n_running), 64'd1);
    tick(15);
    check_nch("wrap_ch0_15", 0, 64'd15);
    check_nch("wrap_ch1_15", 1, 64'd15);
    check("wrap_ovf_pre", 64'(n_ovf), 64'd0);
    tick(1);
    check_nch("wrap_ch0_0", 0, 64'd0);
    check("wrap_ovf_set", 64'(n_ovf), 64'b00011);
    tick(3);
    check_nch("wrap_ch0_3", 0, 64'd3);
    check("wrap_ovf_sticky", 64'(n_ovf), 64'b00011);
    n_sel = 3'd7;
    #1;
    check("sel_oob", 64'(n_data), 64'd0);
    n_clear = 1'b1;
    tick(1);
    n_clear = 1'b0;
    check("n_clr_ovf", 64'(n_ovf), 64'd0);
    check("n_clr_running", 64'(n_running), 64'd0);

`ifdef PERF_SNAPSHOT_EN
    // Snapshot captures the pre-increment live value and holds it for readout.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(42);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    rd_sel = 2'd0;
    #1;
    check("snap_42", 64'(rd_data), 64'd42);
    tick(7);
    check("snap_hold_42", 64'(rd_data), 64'd42);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    check("snap_50", 64'(rd_data), 64'd50);
    clear = 1'b1; snap = 1'b1;
    tick(1);
    clear = 1'b0; snap = 1'b0;
    check("snap_clr", 64'(rd_data), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
